// File: rtl/signed_sequential_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : signed_sequential_divider_if
// Description : Request/result bundle for the signed sequential divider.
// Revision    : 1.0  initial release
// ============================================================================
interface signed_sequential_divider_if;
    logic        start;
    logic [15:0] InA;
    logic [7:0]  InB;
    logic        IsDone;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        IsNeg;
    logic        RemNeg;
    logic        DivZero;

    modport master (
        output start, InA, InB,
        input  IsDone, quotient, remainder, IsNeg, RemNeg, DivZero
    );

    modport slave (
        input  start, InA, InB,
        output IsDone, quotient, remainder, IsNeg, RemNeg, DivZero
    );
endinterface
`default_nettype wire

// File: rtl/signed_sequential_divider.sv
`default_nettype none
// ============================================================================
// Module      : signed_sequential_divider
// Description : Radix-2 restoring 16/8 signed divider, magnitude+sign results.
// Revision    : 1.0  initial release
// ============================================================================
module signed_sequential_divider (
    input  wire logic                      clk,
    input  wire logic                      reset,
    signed_sequential_divider_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_ZERO = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_dvd;
    logic [7:0]  r_dsr;
    logic [7:0]  r_prem;
    logic [3:0]  r_cnt;
    logic        r_sign_q;
    logic        r_sign_r;

    logic [15:0] r_quotient;
    logic [7:0]  r_remainder;
    logic        r_is_neg;
    logic        r_rem_neg;
    logic        r_div_zero;

    logic        w_accept;
    logic [15:0] w_a_mag;
    logic [7:0]  w_b_mag;
    logic [8:0]  w_shift_rem;
    logic        w_q_bit;
    logic [7:0]  w_rem_next;
    logic [15:0] w_dvd_next;
    logic        w_last;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_a_mag  = bus.InA[15] ? (~bus.InA + 16'd1) : bus.InA;
    assign w_b_mag  = bus.InB[7]  ? (~bus.InB + 8'd1)  : bus.InB;

    // Partial remainder stays below the divisor (<= 128), so it is stored in
    // 8 bits; only the shifted value needs the 9th bit for the trial compare.
    assign w_shift_rem = {r_prem, r_dvd[15]};
    assign w_q_bit     = (w_shift_rem >= {1'b0, r_dsr});
    assign w_rem_next  = w_q_bit ? (w_shift_rem[7:0] - r_dsr) : w_shift_rem[7:0];
    assign w_dvd_next  = {r_dvd[14:0], w_q_bit};
    assign w_last      = (r_state == S_DIV) && (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (bus.InB == 8'd0) ? S_ZERO : S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_IDLE;
                end
            end
            S_ZERO:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvd       <= 16'd0;
            r_dsr       <= 8'd0;
            r_prem      <= 8'd0;
            r_cnt       <= 4'd0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_quotient  <= 16'd0;
            r_remainder <= 8'd0;
            r_is_neg    <= 1'b0;
            r_rem_neg   <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dvd    <= w_a_mag;
                r_dsr    <= w_b_mag;
                r_prem   <= 8'd0;
                r_cnt    <= 4'd15;
                r_sign_q <= bus.InA[15] ^ bus.InB[7];
                r_sign_r <= bus.InA[15];
            end
            if (r_state == S_DIV) begin
                r_prem <= w_rem_next;
                r_dvd  <= w_dvd_next;
                r_cnt  <= r_cnt - 4'd1;
            end
            if (w_last) begin
                r_quotient  <= w_dvd_next;
                r_remainder <= w_rem_next;
                r_is_neg    <= r_sign_q & (|w_dvd_next);
                r_rem_neg   <= r_sign_r & (|w_rem_next);
                r_div_zero  <= 1'b0;
            end
            if (r_state == S_ZERO) begin
                r_quotient  <= 16'd0;
                r_remainder <= 8'd0;
                r_is_neg    <= 1'b0;
                r_rem_neg   <= 1'b0;
                r_div_zero  <= 1'b1;
            end
        end
    end

    assign bus.IsDone    = (r_state == S_IDLE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.IsNeg     = r_is_neg;
    assign bus.RemNeg    = r_rem_neg;
    assign bus.DivZero   = r_div_zero;
endmodule
`default_nettype wire
